// File: rtl/axil_sram_ctrl.sv
// axil_sram_ctrl: AXI-Lite slave that round-robins buffered reads/writes onto one synchronous SRAM port.
// Optional macro AXIL_SRAM_CTRL_STATS_EN adds saturating OKAY-response counters rd_count/wr_count.
module axil_sram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 22,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  output logic [1:0]                s_axil_bresp,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic                      mem_en,
  output logic [DATA_WIDTH/8-1:0]   mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
`ifdef AXIL_SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]               rd_count,
  output logic [15:0]               wr_count
`endif
);
  typedef enum logic [2:0] {IDLE, ACCESS, RWAIT, RRESP, BRESP} state_t;
  state_t state, state_nx;
  logic aw_full, w_full, ar_full, last_wr, op_wr;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH/8-1:0] w_strb, wr_strb;
  logic [1:0] lat;
  logic wr_pend, grant_rd, grant_wr, aw_ok, ar_ok, lat_done;
  logic unused;
  assign unused = ^{s_axil_awprot, s_axil_arprot, aw_addr[1:0], ar_addr[1:0]};
  assign s_axil_awready = !aw_full;
  assign s_axil_wready = !w_full;
  assign s_axil_arready = !ar_full;
  assign wr_pend = aw_full && w_full;
  // read wins unless a write is also pending and the previous tie went to a read
  assign grant_rd = (state == IDLE) && ar_full && (!wr_pend || last_wr);
  assign grant_wr = (state == IDLE) && wr_pend && !grant_rd;
  assign aw_ok = aw_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0;
  assign ar_ok = ar_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0;
  assign lat_done = lat == 2'(READ_LATENCY - 1);
  always_comb begin
    state_nx = state;
    mem_en = 1'b0;
    mem_we = '0;
    s_axil_bvalid = 1'b0;
    s_axil_rvalid = 1'b0;
    case (state)
      IDLE:   state_nx = grant_rd ? (ar_ok ? ACCESS : RRESP) : grant_wr ? (aw_ok ? ACCESS : BRESP) : IDLE;
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = op_wr ? wr_strb : '0;
        state_nx = op_wr ? BRESP : RWAIT;
      end
      RWAIT:  state_nx = lat_done ? RRESP : RWAIT;
      RRESP:  begin
        s_axil_rvalid = 1'b1;
        state_nx = s_axil_rready ? IDLE : RRESP;
      end
      BRESP:  begin
        s_axil_bvalid = 1'b1;
        state_nx = s_axil_bready ? IDLE : BRESP;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      wr_strb <= '0;
      last_wr <= 1'b1;
      op_wr <= 1'b0;
      lat <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
      s_axil_bresp <= 2'b00;
    end else begin
      state <= state_nx;
      if (grant_wr) aw_full <= 1'b0;
      if (grant_wr) w_full <= 1'b0;
      if (grant_rd) ar_full <= 1'b0;
      if (s_axil_awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (s_axil_wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (s_axil_arvalid && !ar_full) begin
        ar_full <= 1'b1;
        ar_addr <= s_axil_araddr;
      end
      // the round-robin pointer only moves when both sides competed
      if (grant_wr && ar_full) last_wr <= 1'b1;
      if (grant_rd && wr_pend) last_wr <= 1'b0;
      if (grant_rd) begin
        op_wr <= 1'b0;
        lat <= '0;
        mem_addr <= ar_addr[MEM_ADDR_WIDTH+1:2];
        s_axil_rdata <= '0;
        s_axil_rresp <= ar_ok ? 2'b00 : 2'b10;
      end
      if (grant_wr) begin
        op_wr <= 1'b1;
        mem_addr <= aw_addr[MEM_ADDR_WIDTH+1:2];
        mem_wdata <= w_data;
        wr_strb <= w_strb;
        s_axil_bresp <= aw_ok ? 2'b00 : 2'b10;
      end
      if (state == RWAIT) lat <= lat + 2'd1;
      if (state == RWAIT && lat_done) s_axil_rdata <= mem_rdata;
    end
  end
`ifdef AXIL_SRAM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (s_axil_rvalid && s_axil_rready && s_axil_rresp == 2'b00 && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (s_axil_bvalid && s_axil_bready && s_axil_bresp == 2'b00 && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end
`endif
endmodule
